// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset and lock indication into a clean core reset, running
// only on the board reference clock so it keeps working while the PLL is down.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             ext_reset_req,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [1:0]       fsm_state
);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CTR_W   = $clog2(MAX_CYC + 1);

    localparam logic [CTR_W-1:0] RST_LAST = CTR_W'(RST_CYCLES - 1);
    localparam logic [CTR_W-1:0] TMO_LAST = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] STB_LAST = CTR_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CTR_W-1:0]       cnt;
    logic                   cnt_hold;
    logic                   relock_inc;
    logic                   timeout_inc;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;

    assign locked_s  = sync[SYNC_STAGES-1];
    assign fsm_state = state;

    // A PLL held in reset cannot be locked, so lock history is discarded while
    // pll_rst is high; WAIT_LOCK then only acts on lock seen after the pulse.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else if (pll_rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        next_state  = state;
        cnt_hold    = 1'b0;
        relock_inc  = 1'b0;
        timeout_inc = 1'b0;
        if (ext_reset_req) begin
            next_state = PLL_RESET;
            cnt_hold   = 1'b1;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cnt == RST_LAST) next_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = STABLE;
                    end else if (cnt == TMO_LAST) begin
                        next_state  = PLL_RESET;
                        timeout_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        next_state = WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        next_state = PLL_RESET;
                        relock_inc = 1'b1;
                    end
                end
                default: next_state = PLL_RESET;
            endcase
        end
    end

    // Outputs are decoded from next_state so they change on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= PLL_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            relock_count  <= '0;
            timeout_count <= '0;
        end else begin
            state <= next_state;
            if (cnt_hold || (next_state != state)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CTR_W'(1);
            end
            pll_rst   <= (next_state == PLL_RESET);
            sys_reset <= (next_state != RUN);
            ready     <= (next_state == RUN);
            if (relock_inc && (relock_count != '1)) begin
                relock_count <= relock_count + CNT_W'(1);
            end
            if (timeout_inc && (timeout_count != '1)) begin
                timeout_count <= timeout_count + CNT_W'(1);
            end
        end
    end
endmodule
